// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: bus widths and the
// memory port arbiter state encoding.
package mips_pkg;

  localparam int MIPS_ADDR_W = 32;
  localparam int MIPS_DATA_W = 32;

  localparam logic [1:0] ARB_IDLE   = 2'b00;
  localparam logic [1:0] ARB_I_BUSY = 2'b01;
  localparam logic [1:0] ARB_D_BUSY = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = ARB_IDLE,
    S_I_BUSY = ARB_I_BUSY,
    S_D_BUSY = ARB_D_BUSY
  } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Wait-cycle counter for the memory port arbiter watchdog.
// Holds at TIMEOUT, where the terminal-count flag is raised.
module arb_wait_counter
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == 8'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !tc_o)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory.
// Define ARB_RR_EN for round-robin on conflicts (default D-over-I).
module memory_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = MIPS_ADDR_W,
  parameter int DATA_W  = MIPS_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              I_Req,
  input  logic [ADDR_W-1:0] I_Addr,
  output logic [DATA_W-1:0] I_Rdata,
  output logic              I_Ack,
  input  logic              D_Req,
  input  logic              D_We,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_Wdata,
  output logic [DATA_W-1:0] D_Rdata,
  output logic              D_Ack,
  output logic              Stall_I,
  output logic              Stall_M,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  input  logic [DATA_W-1:0] Mem_Rdata,
  input  logic              Mem_Ready,
  output logic              Mem_Err
);

  arb_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;

  logic i_elig, d_elig, pick_d;
  logic busy, tc, done, tmo;

  // A port whose Ack is high still shows the Req of the finished access
  assign i_elig = I_Req & ~i_ack_q;
  assign d_elig = D_Req & ~d_ack_q;

`ifdef ARB_RR_EN
  logic last_d_q;

  assign pick_d = d_elig & (~i_elig | ~last_d_q);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      last_d_q <= 1'b0;
    else if (state_q == S_IDLE && (d_elig || i_elig))
      last_d_q <= pick_d;
  end
`else
  assign pick_d = d_elig;
`endif

  assign busy = (state_q != S_IDLE);
  assign tmo  = busy & ~Mem_Ready & tc;
  assign done = busy & (Mem_Ready | tc);

  arb_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clk_i (Clk),
    .rst_i (Rst),
    .clr_i (~busy),
    .en_i  (busy & ~Mem_Ready),
    .tc_o  (tc)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = err_q | tmo;
    unique case (state_q)
      S_IDLE: begin
        if (pick_d) begin
          state_d = S_D_BUSY;
          req_d   = 1'b1;
          we_d    = D_We;
          addr_d  = D_Addr;
          wdata_d = D_Wdata;
        end else if (i_elig) begin
          state_d = S_I_BUSY;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = I_Addr;
          wdata_d = '0;
        end
      end
      S_I_BUSY: begin
        if (done) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = tmo ? '0 : Mem_Rdata;
        end
      end
      S_D_BUSY: begin
        if (done) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = (tmo || we_q) ? '0 : Mem_Rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  assign I_Rdata   = i_rdata_q;
  assign D_Rdata   = d_rdata_q;
  assign I_Ack     = i_ack_q;
  assign D_Ack     = d_ack_q;
  assign Stall_I   = I_Req & ~i_ack_q;
  assign Stall_M   = D_Req & ~d_ack_q;
  assign Mem_Req   = req_q;
  assign Mem_We    = we_q;
  assign Mem_Addr  = addr_q;
  assign Mem_Wdata = wdata_q;
  assign Mem_Err   = err_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter with a
// transaction-level latency/priority model and random traffic.
module tb_memory_port_arbiter;

  localparam int TMO = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        I_Req, D_Req, D_We, Mem_Ready;
  logic [31:0] I_Addr, D_Addr, D_Wdata, Mem_Rdata;
  logic [31:0] I_Rdata, D_Rdata, Mem_Addr, Mem_Wdata;
  logic        I_Ack, D_Ack, Stall_I, Stall_M;
  logic        Mem_Req, Mem_We, Mem_Err;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic        err_m;
  logic [31:0] last_i, last_d;
  bit          last_was_d;

  memory_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .I_Req     (I_Req),
    .I_Addr    (I_Addr),
    .I_Rdata   (I_Rdata),
    .I_Ack     (I_Ack),
    .D_Req     (D_Req),
    .D_We      (D_We),
    .D_Addr    (D_Addr),
    .D_Wdata   (D_Wdata),
    .D_Rdata   (D_Rdata),
    .D_Ack     (D_Ack),
    .Stall_I   (Stall_I),
    .Stall_M   (Stall_M),
    .Mem_Req   (Mem_Req),
    .Mem_We    (Mem_We),
    .Mem_Addr  (Mem_Addr),
    .Mem_Wdata (Mem_Wdata),
    .Mem_Rdata (Mem_Rdata),
    .Mem_Ready (Mem_Ready),
    .Mem_Err   (Mem_Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Called on the first Mem_Req cycle. The memory answers
  // lat cycles later; beyond TMO the watchdog completes it.
  task automatic serve(input bit exp_d,
                       input bit we,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [31:0] mrd,
                       input int lat);
    int k;
    bit got;
    bit tmo;
    logic [31:0] exp_rd;
    chk("mem_req_rise", {31'b0, Mem_Req}, 1);
    chk("mem_addr", Mem_Addr, addr);
    chk("mem_we", {31'b0, Mem_We}, {31'b0, we});
    if (exp_d && we) chk("mem_wdata", Mem_Wdata, wdata);
    got = 0;
    k = 0;
    Mem_Rdata = mrd;
    while (!got && k < 300) begin
      Mem_Ready = (k == lat);
      @(negedge Clk);
      k++;
      if (I_Ack || D_Ack) got = 1;
      else begin
        chk("addr_hold", Mem_Addr, addr);
        if (exp_d && we) chk("wdata_hold", Mem_Wdata, wdata);
      end
    end
    chk("ack_seen", {31'b0, got}, 1);
    tmo = (lat > TMO);
    chk("ack_latency", k, (tmo ? TMO : lat) + 1);
    chk("d_ack", {31'b0, D_Ack}, {31'b0, exp_d});
    chk("i_ack", {31'b0, I_Ack}, {31'b0, !exp_d});
    exp_rd = (tmo || we) ? 32'h0 : mrd;
    if (exp_d) begin
      chk("d_rdata", D_Rdata, exp_rd);
      chk("stall_m_ack", {31'b0, Stall_M}, 0);
      last_d = exp_rd;
    end else begin
      chk("i_rdata", I_Rdata, exp_rd);
      chk("stall_i_ack", {31'b0, Stall_I}, 0);
      last_i = exp_rd;
    end
    chk("mem_req_drop", {31'b0, Mem_Req}, 0);
    err_m = err_m | tmo;
    chk("mem_err", {31'b0, Mem_Err}, {31'b0, err_m});
    Mem_Ready = 0;
  endtask

  // mode 0 = fetch, 1 = data, 2 = both at once
  task automatic run_txn(input int mode,
                         input bit we,
                         input logic [31:0] ia,
                         input logic [31:0] da,
                         input logic [31:0] wd,
                         input logic [31:0] ird,
                         input logic [31:0] drd,
                         input int ilat,
                         input int dlat);
    bit first_d;
    chk("i_rdata_hold", I_Rdata, last_i);
    chk("d_rdata_hold", D_Rdata, last_d);
    I_Addr  = ia;
    D_Addr  = da;
    D_We    = we;
    D_Wdata = wd;
    I_Req   = (mode != 1);
    D_Req   = (mode != 0);
    #1;
    chk("stall_i_req", {31'b0, Stall_I}, {31'b0, I_Req});
    chk("stall_m_req", {31'b0, Stall_M}, {31'b0, D_Req});
    first_d = (mode == 1) ||
              (mode == 2 && (!RR || !last_was_d));
    @(negedge Clk);
    if (first_d) serve(1, we, da, wd, drd, dlat);
    else         serve(0, 0, ia, 0, ird, ilat);
    last_was_d = first_d;
    if (mode == 2) begin
      if (first_d) begin
        D_Req = 0;
        chk("stall_i_pend", {31'b0, Stall_I}, 1);
      end else begin
        I_Req = 0;
        chk("stall_m_pend", {31'b0, Stall_M}, 1);
      end
      @(negedge Clk);
      if (first_d) serve(0, 0, ia, 0, ird, ilat);
      else         serve(1, we, da, wd, drd, dlat);
      last_was_d = !first_d;
    end
    I_Req = 0;
    D_Req = 0;
    @(negedge Clk);
    chk("idle_req", {31'b0, Mem_Req}, 0);
    chk("idle_ack", {30'b0, I_Ack, D_Ack}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=done");
    $fatal(1, "bench time limit");
  end

  initial begin
    Rst = 1; I_Req = 0; D_Req = 0; D_We = 0;
    I_Addr = 0; D_Addr = 0; D_Wdata = 0;
    Mem_Rdata = 0; Mem_Ready = 0;
    err_m = 0; last_i = 0; last_d = 0; last_was_d = 0;
    repeat (2) @(negedge Clk);
    chk("rst_mem_req", {31'b0, Mem_Req}, 0);
    chk("rst_mem_we", {31'b0, Mem_We}, 0);
    chk("rst_mem_addr", Mem_Addr, 0);
    chk("rst_mem_wdata", Mem_Wdata, 0);
    chk("rst_i_rdata", I_Rdata, 0);
    chk("rst_d_rdata", D_Rdata, 0);
    chk("rst_acks", {30'b0, I_Ack, D_Ack}, 0);
    chk("rst_err", {31'b0, Mem_Err}, 0);
    Rst = 0;
    Mem_Ready = 1;
    @(negedge Clk);
    chk("idle_ready_ignored", {30'b0, I_Ack, D_Ack}, 0);
    Mem_Ready = 0;

    run_txn(0, 0, 32'h0040_0000, 0, 0,
            32'h2008_0005, 0, 2, 0);
    run_txn(2, 0, 32'h0040_0004, 32'h1000_0004, 0,
            32'h0123_4567, 32'h8C08_0000, 0, 1);
    run_txn(1, 1, 0, 32'h1000_0008, 32'hDEAD_BEEF,
            0, 32'h5555_AAAA, 0, 3);
    run_txn(1, 0, 0, 32'h1000_000C, 0,
            0, 32'h7777_1111, 0, TMO);
    run_txn(0, 0, 32'h0040_0008, 0, 0,
            32'hFFFF_FFFF, 0, 1000, 0);
    chk("err_sticky", {31'b0, Mem_Err}, 1);

    for (int n = 0; n < 40; n++) begin
      run_txn(int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom,
              $urandom, $urandom,
              int'($urandom_range(0, 5)),
              int'($urandom_range(0, 5)));
    end
    chk("err_sticky_end", {31'b0, Mem_Err}, 1);

    D_We = 0;
    D_Addr = 32'h1000_0010;
    D_Req = 1;
    @(negedge Clk);
    chk("rst_mid_busy", {31'b0, Mem_Req}, 1);
    @(negedge Clk);
    Rst = 1;
    #1;
    chk("rst_mid_req", {31'b0, Mem_Req}, 0);
    chk("rst_mid_acks", {30'b0, I_Ack, D_Ack}, 0);
    chk("rst_mid_err", {31'b0, Mem_Err}, 0);
    chk("rst_mid_addr", Mem_Addr, 0);
    D_Req = 0;
    err_m = 0; last_i = 0; last_d = 0; last_was_d = 0;
    @(negedge Clk);
    Rst = 0;
    Mem_Ready = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge Clk);
      chk("post_rst_req", {31'b0, Mem_Req}, 0);
      chk("post_rst_ack", {30'b0, I_Ack, D_Ack}, 0);
    end
    Mem_Ready = 0;
    run_txn(2, 0, 32'h0040_0010, 32'h1000_0014, 0,
            32'hCAFE_0001, 32'hCAFE_0002, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
